// File: rtl/clint_timer.sv
// CLINT-style machine timer and software interrupt source: mtime, mtimecmp and msip registers
// behind a single-outstanding request/response slave port.
module clint_timer #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_error_o,
  output logic                  timer_interrupt_o,
  output logic                  software_interrupt_o
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  localparam logic [ADDR_WIDTH-1:0] AddrMsip    = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] AddrCmpLo   = ADDR_WIDTH'(16'h4000);
  localparam logic [ADDR_WIDTH-1:0] AddrCmpHi   = ADDR_WIDTH'(16'h4004);
  localparam logic [ADDR_WIDTH-1:0] AddrMtimeLo = ADDR_WIDTH'(16'hBFF8);
  localparam logic [ADDR_WIDTH-1:0] AddrMtimeHi = ADDR_WIDTH'(16'hBFFC);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e            state_q, state_d;
  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic              msip_q, msip_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_error_q, resp_error_d;
  logic              timer_irq_q, timer_irq_d;
  logic              sw_irq_q, sw_irq_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi, hit;
  logic accept, wr, tick;
  logic [31:0] rd_val;
  logic unused_addr_lsbs;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign unused_addr_lsbs = ^req_addr_i[1:0];
  assign word_addr    = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign sel_msip     = (word_addr == AddrMsip);
  assign sel_cmp_lo   = (word_addr == AddrCmpLo);
  assign sel_cmp_hi   = (word_addr == AddrCmpHi);
  assign sel_mtime_lo = (word_addr == AddrMtimeLo);
  assign sel_mtime_hi = (word_addr == AddrMtimeHi);
  assign hit          = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mtime_lo | sel_mtime_hi;

  assign accept = req_valid_i && (state_q == StIdle);
  assign wr     = accept && req_write_i;
  assign tick   = (presc_q == PrescMax);

  always_comb begin
    rd_val = 32'd0;
    if (sel_msip)     rd_val = {31'd0, msip_q};
    if (sel_cmp_lo)   rd_val = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_val = mtimecmp_q[63:32];
    if (sel_mtime_lo) rd_val = mtime_q[31:0];
    if (sel_mtime_hi) rd_val = mtime_q[63:32];
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_error_d = !hit;
          resp_rdata_d = (req_write_i || !hit) ? 32'd0 : rd_val;
        end
      end
      StResp: state_d = StIdle;
    endcase
  end

  // A write to either mtime half overrides (and drops) a coincident tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PrescW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && sel_mtime_lo) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], req_wdata_i, req_wstrb_i)};
    end
    if (wr && sel_mtime_hi) begin
      mtime_d = {merge_bytes(mtime_q[63:32], req_wdata_i, req_wstrb_i), mtime_q[31:0]};
    end
    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], req_wdata_i, req_wstrb_i);
    end
    if (wr && sel_cmp_hi) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_wdata_i, req_wstrb_i);
    end
    msip_d = msip_q;
    if (wr && sel_msip && req_wstrb_i[0]) msip_d = req_wdata_i[0];
    timer_irq_d = (mtime_q >= mtimecmp_q);
    sw_irq_d    = msip_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mtime_q      <= 64'd0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q       <= 1'b0;
      presc_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
      timer_irq_q  <= 1'b0;
      sw_irq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      presc_q      <= presc_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      timer_irq_q  <= timer_irq_d;
      sw_irq_q     <= sw_irq_d;
    end
  end

  assign req_ready_o          = (state_q == StIdle);
  assign resp_valid_o         = resp_valid_q;
  assign resp_rdata_o         = resp_rdata_q;
  assign resp_error_o         = resp_error_q;
  assign timer_interrupt_o    = timer_irq_q;
  assign software_interrupt_o = sw_irq_q;

endmodule
